// File: rtl/battle_pkg.sv
// Shared codes for the turn-based combat sequencer: attack types, hit outcomes, FSM states.
package battle_pkg;

  typedef enum logic [1:0] {
    STANDBY = 2'b00,
    LIGHT   = 2'b01,
    HEAVY   = 2'b10
  } atk_t;

  typedef enum logic [1:0] {
    NO_HIT   = 2'b00,
    CRITICAL = 2'b01,
    NORMAL   = 2'b10,
    MISS     = 2'b11
  } hit_t;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_ATTACK = 3'd1,
    ISSUE       = 3'd2,
    RESOLVE     = 3'd3,
    GAME_OVER   = 3'd4
  } state_t;

  // Code 11 is deliberately not an attack; it behaves like STANDBY.
  function automatic logic is_attack(input logic [1:0] t);
    return (t == LIGHT) || (t == HEAVY);
  endfunction

endpackage

// File: rtl/damage_calc.sv
// Combinational damage from attack type and hit outcome; critical doubles the base.
// Zero latency, no flow control.
module damage_calc
  import battle_pkg::*;
#(
  parameter int HP_WIDTH  = 8,
  parameter int LIGHT_DMG = 10,
  parameter int HEAVY_DMG = 20
) (
  input  logic [1:0]        atk_type,
  input  logic [1:0]        hit_state,
  output logic [HP_WIDTH:0] damage
);

  localparam int DW = HP_WIDTH + 1;

  logic [HP_WIDTH:0] base;

  always_comb begin
    base = '0;
    case (atk_type)
      LIGHT:   base = DW'(LIGHT_DMG);
      HEAVY:   base = DW'(HEAVY_DMG);
      default: base = '0;
    endcase

    damage = '0;
    case (hit_state)
      CRITICAL: damage = base << 1;
      NORMAL:   damage = base;
      default:  damage = '0;
    endcase
  end

endmodule

// File: rtl/battle_resolver.sv
// Turn-based combat sequencer: accept attack, issue to outcome generator, resolve damage 2 edges later.
// Attacks are taken only while o_attack_ready is high; i_start restarts from any state.
module battle_resolver
  import battle_pkg::*;
#(
  parameter int HP_WIDTH  = 8,
  parameter int MAX_HP    = 100,
  parameter int LIGHT_DMG = 10,
  parameter int HEAVY_DMG = 20
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_attack_valid,
  input  logic [1:0]          i_attack_type,
  output logic                o_attack_ready,
  output logic [1:0]          o_type,
  output logic                o_isPlayer,
  input  logic [1:0]          i_hit_state,
  output logic [HP_WIDTH-1:0] o_player_hp,
  output logic [HP_WIDTH-1:0] o_cpu_hp,
  output logic [HP_WIDTH:0]   o_last_damage,
  output logic                o_result_valid,
  output logic                o_game_over,
  output logic                o_player_won
);

  localparam logic [HP_WIDTH-1:0] HP_FULL = HP_WIDTH'(MAX_HP);

  state_t              state, state_nxt;
  logic [HP_WIDTH-1:0] player_hp, player_hp_nxt;
  logic [HP_WIDTH-1:0] cpu_hp, cpu_hp_nxt;
  logic [HP_WIDTH-1:0] def_hp, def_hp_new;
  logic [HP_WIDTH:0]   dmg, last_dmg, last_dmg_nxt;
  logic [1:0]          atk_type, atk_type_nxt;
  logic                is_player, is_player_nxt;
  logic                result_vld, result_vld_nxt;
  logic                game_over, game_over_nxt;
  logic                player_won, player_won_nxt;

  damage_calc #(
    .HP_WIDTH  (HP_WIDTH),
    .LIGHT_DMG (LIGHT_DMG),
    .HEAVY_DMG (HEAVY_DMG)
  ) u_damage_calc (
    .atk_type  (atk_type),
    .hit_state (i_hit_state),
    .damage    (dmg)
  );

  // Saturating subtract: damage is one bit wider than HP, so compare before subtracting.
  always_comb begin
    def_hp     = is_player ? cpu_hp : player_hp;
    def_hp_new = (dmg >= {1'b0, def_hp}) ? '0 : def_hp - dmg[HP_WIDTH-1:0];
  end

  always_comb begin
    state_nxt      = state;
    player_hp_nxt  = player_hp;
    cpu_hp_nxt     = cpu_hp;
    last_dmg_nxt   = last_dmg;
    atk_type_nxt   = atk_type;
    is_player_nxt  = is_player;
    result_vld_nxt = 1'b0;
    game_over_nxt  = game_over;
    player_won_nxt = player_won;

    if (i_start) begin
      state_nxt      = WAIT_ATTACK;
      player_hp_nxt  = HP_FULL;
      cpu_hp_nxt     = HP_FULL;
      last_dmg_nxt   = '0;
      atk_type_nxt   = STANDBY;
      is_player_nxt  = 1'b1;
      game_over_nxt  = 1'b0;
      player_won_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: ;
        WAIT_ATTACK: begin
          if (i_attack_valid && is_attack(i_attack_type)) begin
            atk_type_nxt = i_attack_type;
            state_nxt    = ISSUE;
          end
        end
        ISSUE: state_nxt = RESOLVE;
        RESOLVE: begin
          if (is_player) cpu_hp_nxt = def_hp_new;
          else           player_hp_nxt = def_hp_new;
          last_dmg_nxt   = dmg;
          result_vld_nxt = 1'b1;
          atk_type_nxt   = STANDBY;
          is_player_nxt  = ~is_player;
          if (def_hp_new == '0) begin
            game_over_nxt  = 1'b1;
            player_won_nxt = is_player;
            state_nxt      = GAME_OVER;
          end else begin
            state_nxt = WAIT_ATTACK;
          end
        end
        GAME_OVER: ;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      player_hp  <= HP_FULL;
      cpu_hp     <= HP_FULL;
      last_dmg   <= '0;
      atk_type   <= STANDBY;
      is_player  <= 1'b1;
      result_vld <= 1'b0;
      game_over  <= 1'b0;
      player_won <= 1'b0;
    end else begin
      player_hp  <= player_hp_nxt;
      cpu_hp     <= cpu_hp_nxt;
      last_dmg   <= last_dmg_nxt;
      atk_type   <= atk_type_nxt;
      is_player  <= is_player_nxt;
      result_vld <= result_vld_nxt;
      game_over  <= game_over_nxt;
      player_won <= player_won_nxt;
    end
  end

  assign o_attack_ready = (state == WAIT_ATTACK);
  assign o_type         = atk_type;
  assign o_isPlayer     = is_player;
  assign o_player_hp    = player_hp;
  assign o_cpu_hp       = cpu_hp;
  assign o_last_damage  = last_dmg;
  assign o_result_valid = result_vld;
  assign o_game_over    = game_over;
  assign o_player_won   = player_won;

endmodule
